// File: rtl/cpu_pkg.sv
// Shared types and encoding constants for the 9-bit CPU control path.
package cpu_pkg;

   typedef enum logic [3:0] {
      OpAnd  = 4'b0000,
      OpOr   = 4'b0001,
      OpNot  = 4'b0010,
      OpAdd  = 4'b0011,
      OpMov  = 4'b0100,
      OpSll  = 4'b0101,
      OpSrl  = 4'b0110,
      OpSub  = 4'b0111,
      OpAddi = 4'b1000,
      OpSubi = 4'b1001,
      OpMovi = 4'b1010,
      OpNop  = 4'b1011,
      OpHalt = 4'b1111
   } opcode_t;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDecode,
      StExec,
      StWb,
      StHalt
   } ctrl_state_t;

   localparam int unsigned PcW    = 10;
   localparam int unsigned InstrW = 16;
   localparam int unsigned ImmW   = 9;
   localparam int unsigned SelW   = 3;
   localparam int unsigned OpMsb  = 15;
   localparam int unsigned OpLsb  = 12;
   localparam int unsigned RdLsb  = 9;
   localparam int unsigned RsLsb  = 6;
   localparam int unsigned RtLsb  = 3;
   localparam int unsigned ImmLsb = 0;

   // Immediate-form ALU ops: rs aliases rd and b comes from imm.
   function automatic logic is_itype(input logic [3:0] op);
      return (op == OpAddi) || (op == OpSubi) || (op == OpMovi);
   endfunction

   // Every opcode that produces a register writeback.
   function automatic logic is_alu(input logic [3:0] op);
      return op <= OpMovi;
   endfunction

   // The three unassigned codes between NOP and HALT.
   function automatic logic is_illegal(input logic [3:0] op);
      return (op == 4'b1100) || (op == 4'b1101) || (op == 4'b1110);
   endfunction

endpackage

// File: rtl/cpu_control_if.sv
// Instruction-memory fetch bus: request/address out, ack/data back.
interface cpu_control_if;
   import cpu_pkg::*;

   logic              imem_req;
   logic [PcW-1:0]    imem_addr;
   logic              imem_ack;
   logic [InstrW-1:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/cpu_control_pc_reg.sv
// 10-bit program counter; wraps naturally from 1023 to 0.
module pc_reg
   import cpu_pkg::*;
(
   input  logic           clock,
   input  logic           reset,
   input  logic           inc_en,
   output logic [PcW-1:0] pc
);

   // Advance by one when enabled.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc <= '0;
      end else if (inc_en) begin
         pc <= pc + PcW'(1);
      end
   end

endmodule

// File: rtl/cpu_control.sv
// Multicycle control unit: fetch over req/ack, decode IR, sequence EXEC/WB.
module cpu_control
   import cpu_pkg::*;
#(
   parameter int unsigned RET_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   cpu_control_if.master    imem,
   output logic [PcW-1:0]   pc,
   output logic [3:0]       alu_opcode,
   output logic [SelW-1:0]  rd_sel,
   output logic [SelW-1:0]  rs_sel,
   output logic [SelW-1:0]  rt_sel,
   output logic             b_imm_sel,
   output logic [ImmW-1:0]  imm,
   output logic             reg_we,
   output logic             halted,
   output logic             illegal,
   output logic [RET_W-1:0] retired
);

   ctrl_state_t       state_q, state_d;
   logic [InstrW-1:0] ir_q;
   logic              illegal_q;
   logic [RET_W-1:0]  retired_q;
   logic              fetch_req, ir_load, pc_inc, set_illegal, wb_we;
   logic [3:0]        op;

   assign op = ir_q[OpMsb:OpLsb];

   pc_reg u_pc_reg (
      .clock  (clock),
      .reset  (reset),
      .inc_en (pc_inc),
      .pc     (pc)
   );

   // State register; reset drops imem_req asynchronously via the state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // IR, sticky illegal flag and saturating retire counter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ir_q      <= '0;
         illegal_q <= 1'b0;
         retired_q <= '0;
      end else begin
         if (ir_load) begin
            ir_q <= imem.imem_rdata;
         end
         if (set_illegal) begin
            illegal_q <= 1'b1;
         end
         if (pc_inc && (retired_q != {RET_W{1'b1}})) begin
            retired_q <= retired_q + {{(RET_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // Next-state and per-state strobes.
   always_comb begin
      state_d     = state_q;
      fetch_req   = 1'b0;
      ir_load     = 1'b0;
      pc_inc      = 1'b0;
      set_illegal = 1'b0;
      wb_we       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StFetch;
            end
         end
         StFetch: begin
            fetch_req = 1'b1;
            if (imem.imem_ack) begin
               ir_load = 1'b1;
               state_d = StDecode;
            end
         end
         StDecode: begin
            if (op == OpHalt) begin
               state_d = StHalt;
            end else if (is_illegal(op)) begin
               set_illegal = 1'b1;
               state_d     = StHalt;
            end else if (op == OpNop) begin
               state_d = StWb;
            end else begin
               state_d = StExec;
            end
         end
         StExec: begin
            state_d = StWb;
         end
         StWb: begin
            wb_we   = is_alu(op);
            pc_inc  = 1'b1;
            state_d = StFetch;
         end
         StHalt: begin
            state_d = StHalt;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign imem.imem_req  = fetch_req;
   assign imem.imem_addr = pc;

   // Decoded fields come straight off IR, so they only move when IR is reloaded.
   assign alu_opcode = op;
   assign rd_sel     = ir_q[RdLsb +: SelW];
   assign rs_sel     = is_itype(op) ? ir_q[RdLsb +: SelW] : ir_q[RsLsb +: SelW];
   assign rt_sel     = ir_q[RtLsb +: SelW];
   assign b_imm_sel  = is_itype(op);
   assign imm        = ir_q[ImmLsb +: ImmW];
   assign reg_we     = wb_we;
   assign halted     = (state_q == StHalt);
   assign illegal    = illegal_q;
   assign retired    = retired_q;

endmodule
